// File: rtl/reg_read_stage_pkg.sv
// Shared definitions for the decode/register-read slice of the pipeline.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 8;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  // Bit offsets inside the opaque decoded-control bundle carried ID->EX.
  // This stage never interprets them; they are shared with decode and execute.
  localparam int CTRL_ALU_OP_LSB = 0;   // 4-bit ALU operation
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_ALU_SRC    = 4;   // 1 = immediate operand
  localparam int CTRL_MEM_WR     = 5;   // store
  localparam int CTRL_REG_WR     = 6;   // writes a destination register
  localparam int CTRL_BRANCH     = 7;   // conditional branch

endpackage

// File: rtl/reg_read_stage_reg_file.sv
// Architectural register file: two combinational read ports with
// write-through of a same-cycle write, one synchronous write port, r0 fixed at 0.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int NUM = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM];
  logic              wr_live;

  // A write to r0 is dropped entirely, so r0 never holds anything but zero.
  assign wr_live = wr_en && (wr_addr != ZERO_ADDR);

  // Synchronous clear on reset, otherwise commit the WB write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 forced to zero, same-cycle write forwarded ahead of the array.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_a == ZERO_ADDR)                  rd_data_a = '0;
    else if (wr_live && rd_addr_a == wr_addr)    rd_data_a = wr_data;
    if (rd_addr_b == ZERO_ADDR)                  rd_data_b = '0;
    else if (wr_live && rd_addr_b == wr_addr)    rd_data_b = wr_data;
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: reads rs/rt for the instruction in ID, detects
// load-use hazards and maintains the ID/EX pipeline register.
//
// Pipeline handshake: ex_valid marks a real instruction in ID/EX. stall holds
// ID/EX unchanged (operands are still refreshed from WB so they never go
// stale); flush replaces it with a bubble and wins over stall. load_use_stall
// tells fetch/decode to hold ID this cycle while a bubble enters EX, unless an
// external stall is already holding ID/EX.
module reg_read_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_dest_addr,
  input  logic              id_mem_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_reg_wr_en,
  input  logic [ADDR_W-1:0] wb_reg_wr_addr,
  input  logic [DATA_W-1:0] wb_reg_wr_data,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs_addr,
  output logic [ADDR_W-1:0] ex_rt_addr,
  output logic [ADDR_W-1:0] ex_dest_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic              ex_mem_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_live;
  logic              rs_dep;
  logic              rt_dep;

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_reg_wr_en),
    .wr_addr   (wb_reg_wr_addr),
    .wr_data   (wb_reg_wr_data),
    .rd_addr_a (id_rs_addr),
    .rd_data_a (rs_data),
    .rd_addr_b (id_rt_addr),
    .rd_data_b (rt_data)
  );

  assign wb_live = wb_reg_wr_en && (wb_reg_wr_addr != ZERO_ADDR);

  // Load in EX whose result ID needs now: the value is not available until
  // after MEM, so ID must wait one cycle. rt only counts if it is really read.
  always_comb begin
    rs_dep         = (ex_dest_addr == id_rs_addr);
    rt_dep         = id_rt_used && (ex_dest_addr == id_rt_addr);
    load_use_stall = !flush && id_valid && ex_valid && ex_mem_rd &&
                     (ex_dest_addr != ZERO_ADDR) && (rs_dep || rt_dep);
  end

  // ID/EX register: reset, flush bubble, hold with WB refresh, hazard bubble, load.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && load_use_stall)) begin
      ex_valid     <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_dest_addr <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_mem_rd    <= 1'b0;
      ex_ctrl      <= '0;
    end else if (stall) begin
      if (wb_live && wb_reg_wr_addr == ex_rs_addr) ex_rs_data <= wb_reg_wr_data;
      if (wb_live && wb_reg_wr_addr == ex_rt_addr) ex_rt_data <= wb_reg_wr_data;
    end else begin
      ex_valid     <= id_valid;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_dest_addr <= id_dest_addr;
      ex_rs_data   <= rs_data;
      ex_rt_data   <= rt_data;
      ex_mem_rd    <= id_mem_rd;
      ex_ctrl      <= id_ctrl;
    end
  end

endmodule
